// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register downstream of the ALU.
// Holds Z/N/C, applies SETC/CLRC and jump-taken flag clears, and keeps
// a LIFO stash of flag triples for nested interrupt entry / RTI.
module ccr_unit #(
    parameter int STACK_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_alu_zero,
    input  logic i_alu_negative,
    input  logic i_alu_carry,
    input  logic i_alu_flags_en,
    input  logic i_setc,
    input  logic i_clrc,
    input  logic i_jz_taken,
    input  logic i_jn_taken,
    input  logic i_jc_taken,
    input  logic i_int_save,
    input  logic i_rti_restore,
    output logic o_zero_flag,
    output logic o_negative_flag,
    output logic o_carry_flag,
    output logic o_stack_empty,
    output logic o_stack_full,
    output logic o_overflow_err,
    output logic o_underflow_err
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(STACK_DEPTH);

    // CCR bit order is {Z, N, C}
    logic [2:0]    ccr_q, ccr_d, ccr_calc;
    logic [PW-1:0] ptr_q, ptr_d, ptr_m1;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [2:0]    stash_q [STACK_DEPTH];
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          empty, full;

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == PTR_FULL);
    assign ptr_m1  = ptr_q - PW'(1);
    assign top_idx = ptr_m1[IW-1:0];

    // Flag update without any stash involvement; later steps override earlier
    always_comb begin
        ccr_calc = ccr_q;
        if (i_alu_flags_en)
            ccr_calc = {i_alu_zero, i_alu_negative, i_alu_carry};
        if (i_setc && !i_clrc)
            ccr_calc[0] = 1'b1;
        else if (i_clrc && !i_setc)
            ccr_calc[0] = 1'b0;
        if (i_jz_taken) ccr_calc[2] = 1'b0;
        if (i_jn_taken) ccr_calc[1] = 1'b0;
        if (i_jc_taken) ccr_calc[0] = 1'b0;
    end

    // Stash control: push, pop, or swap when both arrive together
    always_comb begin
        ccr_d  = ccr_calc;
        ptr_d  = ptr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q[IW-1:0];
        if (i_int_save && i_rti_restore) begin
            if (!empty) begin
                ccr_d  = stash_q[top_idx];
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (!full) begin
                // empty swap degenerates to a plain push, no underflow
                wr_en = 1'b1;
                ptr_d = ptr_q + PW'(1);
            end
        end else if (i_int_save) begin
            if (!full) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (i_rti_restore) begin
            if (!empty) begin
                ccr_d = stash_q[top_idx];
                ptr_d = ptr_m1;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Architectural state with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ccr_q <= 3'b000;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ccr_q <= ccr_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stash storage always saves the pre-update CCR; contents need no reset
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst)
            stash_q[wr_idx] <= ccr_q;
    end

    assign o_zero_flag     = ccr_q[2];
    assign o_negative_flag = ccr_q[1];
    assign o_carry_flag    = ccr_q[0];
    assign o_stack_empty   = empty;
    assign o_stack_full    = full;
    assign o_overflow_err  = ovf_q;
    assign o_underflow_err = unf_q;

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register (CCR) stage directly downstream of the ALU in execute-memory.
- Latches the ALU's Z/N/C outputs and feeds them back to the ALU flag inputs on the next instruction.
- Applies SETC/CLRC and flag-consuming conditional jumps (JZ/JN/JC clear the tested flag).
- Provides a LIFO flag stash for interrupt entry (save) and RTI (restore), supporting nested interrupts.

Parameters:
STACK_DEPTH, 4, number of flag triples the interrupt stash holds (>=1)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_alu_zero  input  1  ALU o_zero_flag
i_alu_negative  input  1  ALU o_negative_flag
i_alu_carry  input  1  ALU o_carry_flag
i_alu_flags_en  input  1  instruction in EX writes flags; load ALU flags
i_setc  input  1  SETC instruction in EX
i_clrc  input  1  CLRC instruction in EX
i_jz_taken  input  1  JZ taken; clear Z
i_jn_taken  input  1  JN taken; clear N
i_jc_taken  input  1  JC taken; clear C
i_int_save  input  1  interrupt entry; push current CCR onto stash
i_rti_restore  input  1  RTI; pop stash into CCR
o_zero_flag  output  1  registered Z, to ALU i_zero_flag and branch unit
o_negative_flag  output  1  registered N
o_carry_flag  output  1  registered C
o_stack_empty  output  1  stash holds 0 entries
o_stack_full  output  1  stash holds STACK_DEPTH entries
o_overflow_err  output  1  sticky; push attempted while full
o_underflow_err  output  1  sticky; pop attempted while empty

Behaviour:
- Reset (i_rst=1 at edge, regardless of other inputs, including mid-interrupt): Z=N=C=0, stash pointer=0, o_stack_empty=1, o_stack_full=0, both error flags=0. Stash contents are don't-care after reset.
- All outputs are registered. An input change is visible on the outputs one cycle later. There is no combinational path from inputs to outputs except that o_stack_empty/o_stack_full are decoded from the registered pointer.
- Next-CCR computation, evaluated in this order (each later step overrides earlier ones):
  1. Start from the current CCR.
  2. If i_alu_flags_en: {Z,N,C} = ALU flags.
  3. If i_setc and not i_clrc: C=1. If i_clrc and not i_setc: C=0. If both are asserted: no change from this step.
  4. If i_jz_taken: Z=0. If i_jn_taken: N=0. If i_jc_taken: C=0. Jump clears may be simultaneous and are independent.
  5. If a valid pop occurs (i_rti_restore and stash not empty): CCR = popped triple, overriding steps 2-4 entirely.
- Push (i_int_save, no restore in the same cycle):
  - If not full: stash[ptr] = current registered CCR (the value before this cycle's update); ptr+1.
  - If full: entry dropped, ptr unchanged, o_overflow_err set; CCR update still proceeds.
- Pop (i_rti_restore, no save in the same cycle):
  - If not empty: CCR = stash[ptr-1]; ptr-1.
  - If empty: CCR follows steps 1-4, o_underflow_err set.
- Save and restore in the same cycle (swap):
  - If not empty: CCR = stash[ptr-1]; stash[ptr-1] = current CCR; ptr unchanged.
  - If empty: treated as push only (underflow is not flagged); CCR follows steps 1-4.
- o_overflow_err/o_underflow_err stay at 1 until reset.
- Pointer width is clog2(STACK_DEPTH+1). The pointer never wraps.

Test Plan:
- Reset -> all three flags 0, o_stack_empty=1. Then i_alu_flags_en=1 with ALU Z/N/C=0/1/1 -> outputs 0/1/1 exactly one cycle later, and unchanged while en=0.
- CCR=0/0/0; i_alu_flags_en=1 with ALU C=0, plus i_setc=1 -> C=1. Next cycle i_setc=i_clrc=1 with en=0 -> C stays 1. Next cycle i_clrc=1 -> C=0.
- CCR Z=1; i_alu_flags_en with ALU Z=1 and i_jz_taken=1 in the same cycle -> Z=0, N/C taken from the ALU.
- With STACK_DEPTH=4: push CCR values 1/0/0, 0/1/0, 0/0/1, 1/1/1 -> o_stack_full=1. A fifth push -> o_overflow_err=1, pointer stays 4. Four pops restore 1/1/1, 0/0/1, 0/1/0, 1/0/0 in that order -> o_stack_empty=1. A fifth pop -> o_underflow_err=1, CCR unchanged.
- Stash holds 1/0/1, CCR=0/1/0; save+restore in the same cycle -> CCR=1/0/1, pointer unchanged. A following pop -> CCR=0/1/0.
- Two entries pushed; i_rst asserted together with i_rti_restore -> flags 0, o_stack_empty=1, errors 0.
